// File: rtl/int_ctrl.sv
// int_ctrl: parametrised PDP-8/E interrupt controller with IOT access.
// Ports: clk, reset, state, instruction, ac, clear, req -> irq, skip, bus.
module int_ctrl #(
    parameter int               NCHAN      = 4,
    parameter logic [5:0]       DEV        = 6'o07,
    parameter logic [NCHAN-1:0] EDGE_MASK  = {NCHAN{1'b1}},
    parameter logic [4:0]       EXEC_STATE = 5'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       state,
    input  logic [0:11]      instruction,
    input  logic [0:11]      ac,
    input  logic             clear,
    input  logic [NCHAN-1:0] req,
    output logic             irq,
    output logic             skip,
    output logic [0:11]      bus
);

    localparam logic [2:0] OP_RDP = 3'd0;
    localparam logic [2:0] OP_SKP = 3'd1;
    localparam logic [2:0] OP_LDE = 3'd2;
    localparam logic [2:0] OP_RDE = 3'd3;
    localparam logic [2:0] OP_CLP = 3'd4;
    localparam logic [2:0] OP_VEC = 3'd5;
    localparam logic [2:0] OP_CLA = 3'd6;
    localparam logic [2:0] OP_SWI = 3'd7;

    logic [NCHAN-1:0] req_d;
    logic [NCHAN-1:0] pend;
    logic [NCHAN-1:0] ena;
    logic [NCHAN-1:0] swp;

    logic [NCHAN-1:0] pend_n;
    logic [NCHAN-1:0] swp_n;
    logic [NCHAN-1:0] ena_n;

    logic [NCHAN-1:0] eff;
    logic [NCHAN-1:0] act;
    logic [NCHAN-1:0] rise;
    logic [NCHAN-1:0] ac_ch;

    logic [11:0] ac_v;
    logic [11:0] bus_v;
    logic [2:0]  op;
    logic        hit;
    logic        vany;
    logic [3:0]  vidx;
    logic        unused_ac;

    // Little-endian view: channel i sits at numeric bit i.
    assign ac_v      = ac;
    assign ac_ch     = ac_v[NCHAN-1:0];
    assign unused_ac = ^ac_v;

    assign op  = instruction[9:11];
    assign hit = (state == EXEC_STATE)
              && (instruction[0:2] == 3'b110)
              && (instruction[3:8] == DEV);

    assign eff  = (EDGE_MASK & pend) | (~EDGE_MASK & req) | swp;
    assign act  = eff & ena;
    assign irq  = |act;
    assign rise = req & ~req_d;

    // Lowest-numbered active channel wins.
    always_comb begin
        vany = 1'b0;
        vidx = 4'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (act[i]) begin
                vany = 1'b1;
                vidx = 4'(i);
            end
        end
    end

    always_comb begin
        bus_v = '0;
        skip  = 1'b0;
        if (hit) begin
            unique case (op)
                OP_RDP: bus_v[NCHAN-1:0] = eff;
                OP_SKP: skip = |act;
                OP_RDE: bus_v[NCHAN-1:0] = ena;
                OP_VEC: begin
                    if (vany) begin
                        bus_v[11]  = 1'b1;
                        bus_v[3:0] = vidx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus = bus_v;

    // Hardware edges are OR-ed in after any clear op so an
    // event coincident with CLP/CLA is never lost.
    always_comb begin
        pend_n = pend;
        swp_n  = swp;
        ena_n  = ena;
        if (hit) begin
            unique case (op)
                OP_LDE: ena_n = ac_ch;
                OP_CLP: begin
                    pend_n = pend & ~ac_ch;
                    swp_n  = swp & ~ac_ch;
                end
                OP_CLA: begin
                    pend_n = '0;
                    swp_n  = '0;
                end
                OP_SWI: swp_n = swp | ac_ch;
                default: ;
            endcase
        end
        pend_n = pend_n | (rise & EDGE_MASK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d <= '0;
            pend  <= '0;
            ena   <= '0;
            swp   <= '0;
        end else if (clear) begin
            req_d <= '0;
            pend  <= '0;
            ena   <= '0;
            swp   <= '0;
        end else begin
            req_d <= req;
            pend  <= pend_n;
            ena   <= ena_n;
            swp   <= swp_n;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed bench for int_ctrl.
// Edge-only and mixed edge/level instances share the IOT bus.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] ac;
    logic        clear;
    logic [3:0]  req;
    logic [3:0]  req_l;
    logic        irq;
    logic        skip;
    logic [0:11] bus;
    logic        irq_l;
    logic        skip_l;
    logic [0:11] bus_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ctrl #(
        .NCHAN(4), .DEV(6'o07),
        .EDGE_MASK(4'b1111), .EXEC_STATE(5'd0)
    ) dut (
        .clk(clk), .reset(reset), .state(state),
        .instruction(instruction), .ac(ac),
        .clear(clear), .req(req),
        .irq(irq), .skip(skip), .bus(bus)
    );

    int_ctrl #(
        .NCHAN(4), .DEV(6'o07),
        .EDGE_MASK(4'b1110), .EXEC_STATE(5'd0)
    ) dut_l (
        .clk(clk), .reset(reset), .state(state),
        .instruction(instruction), .ac(ac),
        .clear(clear), .req(req_l),
        .irq(irq_l), .skip(skip_l), .bus(bus_l)
    );

    task automatic check(input string tag,
                         input logic [11:0] got,
                         input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %o want %o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic iot(input logic [2:0] op,
                       input logic [11:0] acv);
        state       = 5'd0;
        instruction = 12'o6070 | {9'd0, op};
        ac          = acv;
        #1;
    endtask

    task automatic idle();
        state       = 5'd0;
        instruction = 12'o0000;
        ac          = 12'o0000;
        #1;
    endtask

    task automatic pulse_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        req   = '0;
        req_l = '0;
        idle();
        step();
        step();
        check("rst_irq", {11'd0, irq}, 12'd0);
        check("rst_skip", {11'd0, skip}, 12'd0);
        check("rst_bus", bus, 12'o0000);
        check("rst_irq_l", {11'd0, irq_l}, 12'd0);
        reset = 1'b0;
        step();

        // Edge on ch2 with all enabled
        iot(3'd2, 12'o0017);
        step();
        idle();
        req = 4'b0100;
        #1;
        check("pre_edge_irq", {11'd0, irq}, 12'd0);
        step();
        req = 4'b0000;
        #1;
        check("edge_irq", {11'd0, irq}, 12'd1);
        iot(3'd1, 12'o0000);
        check("skp", {11'd0, skip}, 12'd1);
        iot(3'd5, 12'o0000);
        check("vec_ch2", bus, 12'o4002);
        iot(3'd0, 12'o0000);
        check("rdp_ch2", bus, 12'o0004);
        instruction = 12'o6100;
        #1;
        check("other_dev_bus", bus, 12'o0000);
        state = 5'd1;
        instruction = 12'o6070;
        #1;
        check("wrong_state_bus", bus, 12'o0000);
        iot(3'd6, 12'o0000);
        step();
        idle();
        check("cla_irq", {11'd0, irq}, 12'd0);

        // Priority and selective clear
        req = 4'b1010;
        step();
        req = 4'b0000;
        step();
        iot(3'd5, 12'o0000);
        check("vec_ch1", bus, 12'o4001);
        iot(3'd4, 12'o0002);
        step();
        iot(3'd5, 12'o0000);
        check("vec_ch3", bus, 12'o4003);
        iot(3'd6, 12'o0000);
        step();
        idle();
        check("cla2_irq", {11'd0, irq}, 12'd0);
        iot(3'd5, 12'o0000);
        check("vec_none", bus, 12'o0000);

        // Edge coincident with CLP on same channel
        iot(3'd4, 12'o0001);
        req = 4'b0001;
        step();
        req = 4'b0000;
        idle();
        check("set_wins_irq", {11'd0, irq}, 12'd1);
        iot(3'd0, 12'o0000);
        check("set_wins_rdp", bus, 12'o0001);
        iot(3'd6, 12'o0000);
        step();

        // clear beats a concurrent SWI
        iot(3'd7, 12'o0004);
        clear = 1'b1;
        step();
        clear = 1'b0;
        iot(3'd0, 12'o0000);
        check("clear_wins_rdp", bus, 12'o0000);
        iot(3'd3, 12'o0000);
        check("clear_wins_rde", bus, 12'o0000);

        // Level channel 0 on dut_l
        pulse_clear();
        iot(3'd2, 12'o0001);
        step();
        idle();
        req_l = 4'b0001;
        #1;
        check("lvl_irq_on", {11'd0, irq_l}, 12'd1);
        iot(3'd4, 12'o0001);
        step();
        idle();
        check("lvl_clp_irq", {11'd0, irq_l}, 12'd1);
        req_l = 4'b0000;
        #1;
        check("lvl_irq_off", {11'd0, irq_l}, 12'd0);
        step();
        check("lvl_no_latch", {11'd0, irq_l}, 12'd0);

        // Software interrupt
        pulse_clear();
        iot(3'd7, 12'o0010);
        step();
        iot(3'd0, 12'o0000);
        check("swi_rdp", bus, 12'o0010);
        check("swi_irq_masked", {11'd0, irq}, 12'd0);
        iot(3'd2, 12'o0010);
        step();
        idle();
        check("swi_irq", {11'd0, irq}, 12'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("fp_clear_irq", {11'd0, irq}, 12'd0);
        iot(3'd3, 12'o0000);
        check("fp_clear_rde", bus, 12'o0000);

        // Async reset mid-IOT
        iot(3'd2, 12'o0017);
        step();
        idle();
        req = 4'b0001;
        step();
        req = 4'b0000;
        iot(3'd7, 12'o0002);
        step();
        idle();
        check("pre_rst_irq", {11'd0, irq}, 12'd1);
        iot(3'd3, 12'o0000);
        check("pre_rst_rde", bus, 12'o0017);
        #1;
        reset = 1'b1;
        #1;
        check("arst_irq", {11'd0, irq}, 12'd0);
        check("arst_bus", bus, 12'o0000);
        iot(3'd1, 12'o0000);
        check("arst_skip", {11'd0, skip}, 12'd0);
        step();
        reset = 1'b0;
        step();
        iot(3'd0, 12'o0000);
        check("post_rst_rdp", bus, 12'o0000);
        iot(3'd3, 12'o0000);
        check("post_rst_rde", bus, 12'o0000);
        iot(3'd5, 12'o0000);
        check("post_rst_vec", bus, 12'o0000);
        idle();
        check("post_rst_irq", {11'd0, irq}, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
